// File: rtl/coin_acceptor.sv
// Coin acceptor front end for a washer: collects credit, issues a one-cycle start pulse,
// returns change or a refund, and watches for the washer failing to start.
module coin_acceptor #(
    parameter int unsigned PRICE    = 6,
    parameter int unsigned START_TO = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] coin_in,
    input  logic       cancel,
    input  logic       busy,
    output logic       coin,
    output logic [3:0] credit,
    output logic       accept_en,
    output logic       reject,
    output logic       change_valid,
    output logic [3:0] change_amt,
    output logic       fault
);

    localparam int unsigned TimerW = (START_TO < 2) ? 1 : $clog2(START_TO);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(START_TO - 1);
    localparam logic [3:0] Price = 4'(PRICE);

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StStart,
        StWaitRun,
        StWaitDone,
        StRefund
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        credit_q, credit_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              fault_q, fault_d;
    logic              coin_q, coin_d;
    logic              accept_q, accept_d;
    logic              reject_q, reject_d;
    logic              cv_q, cv_d;
    logic [3:0]        amt_q, amt_d;

    logic       coin_present;
    logic [3:0] coin_val;
    logic [4:0] sum;
    logic [3:0] diff;

    function automatic logic [3:0] coin_value(input logic [1:0] c);
        case (c)
            2'b01:   return 4'd1;
            2'b10:   return 4'd2;
            2'b11:   return 4'd5;
            default: return 4'd0;
        endcase
    endfunction

    assign coin_present = (coin_in != 2'b00);
    assign coin_val     = coin_value(coin_in);
    assign sum          = {1'b0, credit_q} + {1'b0, coin_val};
    assign diff         = credit_q - Price;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        timer_d  = '0;
        fault_d  = fault_q;
        coin_d   = 1'b0;
        reject_d = 1'b0;
        cv_d     = 1'b0;
        amt_d    = 4'd0;

        case (state_q)
            StIdle: begin
                if (coin_present) begin
                    credit_d = coin_val;
                    state_d  = StCollect;
                end
            end
            StCollect: begin
                if (cancel) begin
                    reject_d = coin_present;
                    cv_d     = 1'b1;
                    amt_d    = credit_q;
                    credit_d = 4'd0;
                    state_d  = StRefund;
                end else if (credit_q >= Price) begin
                    // Committed to starting: a coin offered now is returned.
                    reject_d = coin_present;
                    coin_d   = 1'b1;
                    amt_d    = diff;
                    cv_d     = (diff != 4'd0);
                    credit_d = 4'd0;
                    state_d  = StStart;
                end else if (coin_present) begin
                    if (sum > 5'd15) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = sum[3:0];
                    end
                end
            end
            StStart: begin
                reject_d = coin_present;
                state_d  = StWaitRun;
            end
            StWaitRun: begin
                reject_d = coin_present;
                if (busy) begin
                    state_d = StWaitDone;
                end else if (timer_q == TimerLast) begin
                    fault_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StWaitDone: begin
                reject_d = coin_present;
                if (!busy) begin
                    state_d = StIdle;
                end
            end
            StRefund: begin
                reject_d = coin_present;
                state_d  = StIdle;
            end
            default: begin
                state_d  = StIdle;
                credit_d = 4'd0;
            end
        endcase

        accept_d = (state_d == StIdle) || (state_d == StCollect);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            credit_q <= 4'd0;
            timer_q  <= '0;
            fault_q  <= 1'b0;
            coin_q   <= 1'b0;
            accept_q <= 1'b1;
            reject_q <= 1'b0;
            cv_q     <= 1'b0;
            amt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
            fault_q  <= fault_d;
            coin_q   <= coin_d;
            accept_q <= accept_d;
            reject_q <= reject_d;
            cv_q     <= cv_d;
            amt_q    <= amt_d;
        end
    end

    assign coin         = coin_q;
    assign credit       = credit_q;
    assign accept_en    = accept_q;
    assign reject       = reject_q;
    assign change_valid = cv_q;
    assign change_amt   = amt_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: a PRICE=6 instance for most scenarios and a
// PRICE=15 instance for the credit ceiling.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] coin_in;
    logic       cancel;
    logic       busy;

    logic       coin, accept_en, reject, change_valid, fault;
    logic [3:0] credit, change_amt;
    logic       h_coin, h_accept_en, h_reject, h_change_valid, h_fault;
    logic [3:0] h_credit, h_change_amt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    coin_acceptor #(.PRICE(6), .START_TO(8)) u_dut (
        .clk(clk), .rst(rst), .coin_in(coin_in), .cancel(cancel), .busy(busy),
        .coin(coin), .credit(credit), .accept_en(accept_en), .reject(reject),
        .change_valid(change_valid), .change_amt(change_amt), .fault(fault)
    );

    coin_acceptor #(.PRICE(15), .START_TO(8)) u_d15 (
        .clk(clk), .rst(rst), .coin_in(coin_in), .cancel(cancel), .busy(busy),
        .coin(h_coin), .credit(h_credit), .accept_en(h_accept_en), .reject(h_reject),
        .change_valid(h_change_valid), .change_amt(h_change_amt), .fault(h_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; coin_in = 2'b00; cancel = 1'b0; busy = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (credit !== 4'd0) begin errors++; $display("FAIL reset_credit got %0d exp 0", credit); end
        checks++; if (accept_en !== 1'b1) begin errors++; $display("FAIL reset_accept got %b exp 1", accept_en); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fault); end
        checks++; if ({coin, reject, change_valid} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {coin, reject, change_valid}); end
        checks++; if (change_amt !== 4'd0) begin errors++; $display("FAIL reset_amt got %0d exp 0", change_amt); end
    endtask

    task automatic test_exact_price();
        do_reset();
        coin_in = 2'b11; tick();
        checks++; if (credit !== 4'd5) begin errors++; $display("FAIL exact_credit5 got %0d exp 5", credit); end
        coin_in = 2'b01; tick();
        checks++; if (credit !== 4'd6) begin errors++; $display("FAIL exact_credit6 got %0d exp 6", credit); end
        checks++; if (coin !== 1'b0) begin errors++; $display("FAIL exact_early_coin got %b exp 0", coin); end
        coin_in = 2'b00; tick();
        checks++; if (coin !== 1'b1) begin errors++; $display("FAIL exact_coin got %b exp 1", coin); end
        checks++; if (change_valid !== 1'b0) begin errors++; $display("FAIL exact_cv got %b exp 0", change_valid); end
        checks++; if ({credit, accept_en} !== 5'b0000_0) begin errors++; $display("FAIL exact_start got %b exp 00000", {credit, accept_en}); end
        tick();
        checks++; if ({coin, change_valid} !== 2'b00) begin errors++; $display("FAIL exact_single_pulse got %b exp 00", {coin, change_valid}); end
        busy = 1'b1; tick();
        checks++; if (accept_en !== 1'b0) begin errors++; $display("FAIL exact_running_accept got %b exp 0", accept_en); end
        busy = 1'b0; tick();
        checks++; if (accept_en !== 1'b1) begin errors++; $display("FAIL exact_idle_accept got %b exp 1", accept_en); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL exact_fault got %b exp 0", fault); end
    endtask

    task automatic test_change();
        do_reset();
        coin_in = 2'b11; tick();
        coin_in = 2'b11; tick();
        checks++; if (credit !== 4'd10) begin errors++; $display("FAIL change_credit got %0d exp 10", credit); end
        coin_in = 2'b00; tick();
        checks++; if ({coin, change_valid} !== 2'b11) begin errors++; $display("FAIL change_pulses got %b exp 11", {coin, change_valid}); end
        checks++; if (change_amt !== 4'd4) begin errors++; $display("FAIL change_amt got %0d exp 4", change_amt); end
        tick();
        checks++; if ({change_valid, change_amt} !== 5'b0_0000) begin errors++; $display("FAIL change_clear got %b exp 00000", {change_valid, change_amt}); end
    endtask

    task automatic test_cancel();
        do_reset();
        cancel = 1'b1; tick();
        checks++; if ({accept_en, change_valid, credit} !== 6'b1_0_0000) begin errors++; $display("FAIL cancel_idle got %b exp 100000", {accept_en, change_valid, credit}); end
        cancel = 1'b0;
        coin_in = 2'b10; tick();
        coin_in = 2'b10; tick();
        checks++; if (credit !== 4'd4) begin errors++; $display("FAIL cancel_credit got %0d exp 4", credit); end
        coin_in = 2'b01; cancel = 1'b1; tick();
        checks++; if (reject !== 1'b1) begin errors++; $display("FAIL cancel_reject got %b exp 1", reject); end
        checks++; if ({change_valid, change_amt} !== 5'b1_0100) begin errors++; $display("FAIL cancel_refund got %b exp 10100", {change_valid, change_amt}); end
        checks++; if (coin !== 1'b0) begin errors++; $display("FAIL cancel_no_start got %b exp 0", coin); end
        coin_in = 2'b00; cancel = 1'b0; tick();
        checks++; if ({accept_en, credit, change_valid, reject} !== 7'b1_0000_0_0) begin errors++; $display("FAIL cancel_idle_after got %b exp 1000000", {accept_en, credit, change_valid, reject}); end
    endtask

    task automatic test_ceiling();
        do_reset();
        repeat (3) begin coin_in = 2'b11; tick(); end
        checks++; if (h_credit !== 4'd15) begin errors++; $display("FAIL ceil_credit15 got %0d exp 15", h_credit); end
        coin_in = 2'b01; tick();
        checks++; if ({h_coin, h_reject} !== 2'b11) begin errors++; $display("FAIL ceil_start_reject got %b exp 11", {h_coin, h_reject}); end
        checks++; if ({h_change_valid, h_change_amt} !== 5'b0_0000) begin errors++; $display("FAIL ceil_no_change got %b exp 00000", {h_change_valid, h_change_amt}); end
        do_reset();
        coin_in = 2'b11; tick();
        coin_in = 2'b11; tick();
        coin_in = 2'b10; tick();
        checks++; if (h_credit !== 4'd12) begin errors++; $display("FAIL ceil_credit12 got %0d exp 12", h_credit); end
        coin_in = 2'b11; tick();
        checks++; if ({h_reject, h_credit} !== 5'b1_1100) begin errors++; $display("FAIL ceil_overflow got %b exp 11100", {h_reject, h_credit}); end
        coin_in = 2'b00; tick();
        checks++; if ({h_reject, h_credit} !== 5'b0_1100) begin errors++; $display("FAIL ceil_hold got %b exp 01100", {h_reject, h_credit}); end
    endtask

    task automatic test_timeout();
        do_reset();
        coin_in = 2'b11; tick();
        coin_in = 2'b01; tick();
        coin_in = 2'b00; tick();
        checks++; if (coin !== 1'b1) begin errors++; $display("FAIL timeout_coin got %b exp 1", coin); end
        repeat (8) tick();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", fault); end
        tick();
        checks++; if ({fault, accept_en} !== 2'b11) begin errors++; $display("FAIL timeout_fault got %b exp 11", {fault, accept_en}); end
        coin_in = 2'b10; tick();
        coin_in = 2'b00; repeat (3) tick();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b exp 1", fault); end
        do_reset();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL timeout_rst_clear got %b exp 0", fault); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        coin_in = 2'b11; tick();
        checks++; if (credit !== 4'd5) begin errors++; $display("FAIL mid_credit got %0d exp 5", credit); end
        coin_in = 2'b00; rst = 1'b1; tick();
        rst = 1'b0;
        checks++; if ({credit, change_valid, accept_en} !== 6'b0000_0_1) begin errors++; $display("FAIL mid_discard got %b exp 000001", {credit, change_valid, accept_en}); end
        tick();
        checks++; if (change_valid !== 1'b0) begin errors++; $display("FAIL mid_no_refund got %b exp 0", change_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        coin_in = 2'b11; tick();
        coin_in = 2'b01; tick();
        coin_in = 2'b00; tick();
        tick();
        busy = 1'b1; tick();
        coin_in = 2'b10; cancel = 1'b1; tick();
        checks++; if ({reject, credit, change_valid} !== 6'b1_0000_0) begin errors++; $display("FAIL b2b_waitdone_reject got %b exp 100000", {reject, credit, change_valid}); end
        coin_in = 2'b00; cancel = 1'b0; busy = 1'b0; tick();
        checks++; if ({accept_en, reject} !== 2'b10) begin errors++; $display("FAIL b2b_idle got %b exp 10", {accept_en, reject}); end
        coin_in = 2'b10; tick();
        checks++; if (credit !== 4'd2) begin errors++; $display("FAIL b2b_next_credit got %0d exp 2", credit); end
        coin_in = 2'b00;
    endtask

    initial begin
        rst = 1'b1; coin_in = 2'b00; cancel = 1'b0; busy = 1'b0;
        test_reset();
        test_exact_price();
        test_change();
        test_cancel();
        test_ceiling();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
